// File: rtl/updown_counter_param.sv
//-----------------------------------------------------------------------------
// Module   : updown_counter_param
// Purpose  : Parametrised up/down counter with count enable, synchronous
//            clamped parallel load, runtime wrap/saturate mode and a
//            combinational terminal-count flag. Optional sticky
//            overflow/underflow status flags.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
// Parameters
//   WIDTH      counter width in bits (2..32)
//   MAX_VAL    highest count value, modulus minus 1 (1..2**WIDTH-1)
//   RESET_VAL  value of q after reset (0..MAX_VAL)
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-low reset
//   en         in   1      count enable
//   load       in   1      synchronous load, priority over en
//   load_val   in   WIDTH  load value, clamped to MAX_VAL
//   up_down    in   1      1 = count up, 0 = count down
//   sat        in   1      1 = saturate at end points, 0 = wrap
//   q          out  WIDTH  registered count
//   tc         out  1      terminal count (combinational from q, up_down)
//   clr_flags  in   1      synchronous clear of ovf/unf     (UDC_STATUS_EN)
//   ovf        out  1      sticky overflow flag             (UDC_STATUS_EN)
//   unf        out  1      sticky underflow flag            (UDC_STATUS_EN)
//
// Build option
//   UDC_STATUS_EN  define to build the ovf/unf/clr_flags ports and flag flops.
//-----------------------------------------------------------------------------
`default_nettype none

module updown_counter_param #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_down,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
`ifdef UDC_STATUS_EN
  input  logic             clr_flags,
  output logic             ovf,
  output logic             unf,
`endif
  output logic             tc
);

  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_ZERO = '0;

  // Elaboration-time guard against illegal configurations.
  generate
    if ((WIDTH < 2) || (WIDTH > 32) || (MAX_VAL == c_ZERO) || (RESET_VAL > MAX_VAL)) begin : g_bad_param
      $error("updown_counter_param: illegal WIDTH/MAX_VAL/RESET_VAL");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_q == MAX_VAL);
  assign w_at_zero = (r_q == c_ZERO);

  // Out-of-range load values are clamped so q never exceeds MAX_VAL.
  assign w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // End points are detected before any arithmetic, so the +1/-1 never needs
  // to produce a value outside 0..MAX_VAL and the adder stays WIDTH bits.
  always_comb begin
    w_q_next = r_q;
    if (load) begin
      w_q_next = w_load_clamped;
    end else if (en) begin
      if (up_down) begin
        if (w_at_max) begin
          w_q_next = sat ? MAX_VAL : c_ZERO;
        end else begin
          w_q_next = r_q + c_ONE;
        end
      end else begin
        if (w_at_zero) begin
          w_q_next = sat ? c_ZERO : MAX_VAL;
        end else begin
          w_q_next = r_q - c_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q  = r_q;

  // Independent of en/load/sat so it can feed the en of a cascaded stage.
  assign tc = (up_down & w_at_max) | (~up_down & w_at_zero);

`ifdef UDC_STATUS_EN
  logic r_ovf;
  logic r_unf;
  logic w_ovf_evt;
  logic w_unf_evt;

  assign w_ovf_evt = en & ~load &  up_down & w_at_max;
  assign w_unf_evt = en & ~load & ~up_down & w_at_zero;

  // A set event on the same edge as clr_flags wins, so no event is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (clr_flags) begin
        r_ovf <= 1'b0;
      end
      if (w_unf_evt) begin
        r_unf <= 1'b1;
      end else if (clr_flags) begin
        r_unf <= 1'b0;
      end
    end
  end

  assign ovf = r_ovf;
  assign unf = r_unf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_param.sv
//-----------------------------------------------------------------------------
// Module   : tb_updown_counter_param
// Purpose  : Directed self-checking bench for updown_counter_param with
//            WIDTH=4, MAX_VAL=9, RESET_VAL=0. Flag checks are included when
//            UDC_STATUS_EN is defined.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_updown_counter_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       up_down;
  logic       sat;
  logic [3:0] q;
  logic       tc;
`ifdef UDC_STATUS_EN
  logic       clr_flags;
  logic       ovf;
  logic       unf;
`endif

  int n_cmp;
  int n_mis;

  updown_counter_param #(
    .WIDTH    (4),
    .MAX_VAL  (4'd9),
    .RESET_VAL(4'd0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .up_down  (up_down),
    .sat      (sat),
    .q        (q),
`ifdef UDC_STATUS_EN
    .clr_flags(clr_flags),
    .ovf      (ovf),
    .unf      (unf),
`endif
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_up [12];
    logic [3:0] exp_dn [4];
    logic       exp_unf[4];
    exp_up  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    exp_dn  = '{4'd1, 4'd0, 4'd0, 4'd0};
    exp_unf = '{1'b0, 1'b0, 1'b1, 1'b1};
    n_cmp = 0;
    n_mis = 0;

    rst      = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    up_down  = 1'b1;
    sat      = 1'b0;
`ifdef UDC_STATUS_EN
    clr_flags = 1'b0;
`endif

    // Reset state
    #12;
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_tc_up", 32'(tc), 32'd0);
`ifdef UDC_STATUS_EN
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_unf", 32'(unf), 32'd0);
`endif
    up_down = 1'b0;
    #1;
    chk("reset_tc_down", 32'(tc), 32'd1);
    up_down = 1'b1;

    // Count up with wrap, 12 edges
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("up_wrap_q[%0d]", i), 32'(q), 32'(exp_up[i]));
      chk($sformatf("up_wrap_tc[%0d]", i), 32'(tc), (exp_up[i] == 4'd9) ? 32'd1 : 32'd0);
`ifdef UDC_STATUS_EN
      chk($sformatf("up_wrap_ovf[%0d]", i), 32'(ovf), (i >= 9) ? 32'd1 : 32'd0);
`endif
    end

    // Load 2 (and clear flags), then count down saturating
    en       = 1'b0;
    load     = 1'b1;
    load_val = 4'd2;
`ifdef UDC_STATUS_EN
    clr_flags = 1'b1;
`endif
    tick();
    chk("load2_q", 32'(q), 32'd2);
`ifdef UDC_STATUS_EN
    chk("clr_ovf", 32'(ovf), 32'd0);
    clr_flags = 1'b0;
`endif
    load    = 1'b0;
    en      = 1'b1;
    up_down = 1'b0;
    sat     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("dn_sat_q[%0d]", i), 32'(q), 32'(exp_dn[i]));
      chk($sformatf("dn_sat_tc[%0d]", i), 32'(tc), (exp_dn[i] == 4'd0) ? 32'd1 : 32'd0);
`ifdef UDC_STATUS_EN
      chk($sformatf("dn_sat_unf[%0d]", i), 32'(unf), 32'(exp_unf[i]));
`endif
    end

    // Load priority and clamp
    up_down  = 1'b1;
    sat      = 1'b0;
    en       = 1'b1;
    load     = 1'b1;
    load_val = 4'd14;
    tick();
    chk("load_clamp_q", 32'(q), 32'd9);
    chk("load_clamp_tc", 32'(tc), 32'd1);
    tick();  // load again at q=9, up, en=1: must not wrap or set ovf
    chk("load_at_max_q", 32'(q), 32'd9);
`ifdef UDC_STATUS_EN
    chk("load_no_ovf", 32'(ovf), 32'd0);
`endif
    en       = 1'b0;
    load_val = 4'd5;
    tick();
    chk("load5_q", 32'(q), 32'd5);
    load = 1'b0;
    tick();
    chk("hold_q", 32'(q), 32'd5);

    // Count to 7, then asynchronous reset between edges
    en = 1'b1;
    tick();
    tick();
    chk("pre_areset_q", 32'(q), 32'd7);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_q", 32'(q), 32'd0);
`ifdef UDC_STATUS_EN
    chk("areset_unf", 32'(unf), 32'd0);
`endif
    #1;
    rst = 1'b1;
    tick();
    chk("resume_q1", 32'(q), 32'd1);
    tick();
    chk("resume_q2", 32'(q), 32'd2);

    // Saturate up at MAX_VAL
    en       = 1'b0;
    load     = 1'b1;
    load_val = 4'd9;
    tick();
    load = 1'b0;
    en   = 1'b1;
    sat  = 1'b1;
    tick();
    chk("up_sat_q", 32'(q), 32'd9);
`ifdef UDC_STATUS_EN
    chk("up_sat_ovf", 32'(ovf), 32'd1);
    // Clear vs set collision: clear the flag first, then collide
    en        = 1'b0;
    clr_flags = 1'b1;
    tick();
    chk("clr_before_collide_ovf", 32'(ovf), 32'd0);
    en  = 1'b1;
    sat = 1'b0;
    tick();
    chk("collide_q", 32'(q), 32'd0);
    chk("collide_ovf", 32'(ovf), 32'd1);
    en = 1'b0;
    tick();
    chk("clr_after_collide_ovf", 32'(ovf), 32'd0);
    chk("clr_hold_q", 32'(q), 32'd0);
    clr_flags = 1'b0;
`else
    sat = 1'b0;
    tick();
    chk("up_wrap_from_max_q", 32'(q), 32'd0);
    en = 1'b0;
`endif

    // Down wrap from 0 to MAX_VAL
    up_down = 1'b0;
    en      = 1'b1;
    tick();
    chk("dn_wrap_q", 32'(q), 32'd9);
    chk("dn_wrap_tc", 32'(tc), 32'd0);
`ifdef UDC_STATUS_EN
    chk("dn_wrap_unf", 32'(unf), 32'd1);
`endif
    tick();
    chk("dn_after_wrap_q", 32'(q), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter: the next generation of the team's fixed 4-bit up/down counter. Adds configurable width and modulus, count enable, synchronous parallel load, runtime wrap/saturate mode, and a terminal-count flag. Optional sticky overflow/underflow status is available for chaining and for software-visible event capture. Used as a general-purpose event, position and timeout counter in datapath and control blocks.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1, highest count value (modulus minus 1); legal range 1..2**WIDTH-1.
- RESET_VAL, 0, value of q after reset; legal range 0..MAX_VAL.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- load  in  1  synchronous parallel load; has priority over en.
- load_val  in  WIDTH  value to load.
- up_down  in  1  direction: 1 = up, 0 = down.
- sat  in  1  mode: 1 = saturate at the end points, 0 = wrap.
- q  out  WIDTH  registered count.
- tc  out  1  combinational terminal-count flag.
- ovf  out  1  sticky overflow flag; present only with UDC_STATUS_EN.
- unf  out  1  sticky underflow flag; present only with UDC_STATUS_EN.
- clr_flags  in  1  synchronous clear for ovf and unf; present only with UDC_STATUS_EN.

## Operation
- Reset (rst=0): q=RESET_VAL, ovf=0, unf=0. Reset takes effect immediately, independent of clk, including mid-count. The first update happens on the first rising edge after rst goes high.
- Per-edge priority: load, then en, then hold.
- Load: q <= min(load_val, MAX_VAL). An out-of-range value is clamped to MAX_VAL. en, up_down and sat are ignored in a load cycle.
- Count (en=1, load=0):
  - Up, q<MAX_VAL: q+1.
  - Up, q==MAX_VAL: wrap to 0 (sat=0), or hold at MAX_VAL (sat=1).
  - Down, q>0: q-1.
  - Down, q==0: wrap to MAX_VAL (sat=0), or hold at 0 (sat=1).
- Hold (en=0, load=0): q unchanged.
- tc = (up_down & q==MAX_VAL) | (~up_down & q==0). tc is independent of en, load and sat, so it can drive the en of a downstream stage for cascading.
- Arithmetic is WIDTH bits wide. Compare against MAX_VAL before incrementing. q never takes a value above MAX_VAL, including when MAX_VAL < 2**WIDTH-1.
- The mode and direction may change on any cycle. The new values apply at the next edge, and no state is retained across the change.

## Timing
- Count and load latency: 1 cycle. q reflects the operation on the edge that samples the controls.
- tc is combinational from q and up_down, so it settles in the same cycle as a direction change.
- ovf/unf (with the macro) set on the edge where an end-point event is sampled:
  - ovf: en & ~load & up_down & q==MAX_VAL.
  - unf: en & ~load & ~up_down & q==0.
  - Set in both wrap and saturate modes. A load cycle never sets a flag.
- Flag set and clear: clr_flags clears both flags on the next edge. If clr_flags and a set condition occur on the same edge, set wins.

## Configuration
- UDC_STATUS_EN defined: the ovf, unf and clr_flags ports and the two flag flops are built, with the behaviour described above.
- UDC_STATUS_EN undefined: none of those ports or flops exist. Counting, load and tc behaviour is identical to the defined case.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9, RESET_VAL=0, with UDC_STATUS_EN defined unless noted.
- Reset and count up with wrap: rst low then high, en=1, up_down=1, sat=0 for 12 edges -> q = 1..9, 0, 1, 2; tc=1 while q==9; ovf=1 after the 9->0 edge.
- Count down with saturate: load 2, then en=1, up_down=0, sat=1 for 4 edges -> q = 1, 0, 0, 0; unf=1 from the 0->0 edge; tc=1 while q==0.
- Load priority and clamp: load=1, en=1, load_val=14 -> q=9 next cycle, no flag set. Then load_val=5 with en=0 -> q=5.
- Asynchronous reset mid-count: rst driven low between edges while q=7 -> q=0 and flags clear immediately, without waiting for clk. Counting resumes from 0 after release.
- Clear vs set collision: q=9, en=1, up_down=1, clr_flags=1 on the same edge -> ovf=1. Next edge with clr_flags=1 and en=0 -> ovf=0.
- Macro off: rebuild without UDC_STATUS_EN and rerun the first scenario -> identical q and tc sequence; the ovf, unf and clr_flags ports are absent.
